// File: rtl/proc_dpath_muldiv_unit.sv
// Iterative multiply/divide/remainder unit for the X stage, val/rdy on both sides.
// Optional macro PROC_MULDIV_EARLY_EXIT_EN shortens MUL and DIVU/REMU iterations.
module proc_dpath_muldiv_unit #(
  parameter int p_nbits   = 32,
  parameter int p_cntbits = $clog2(p_nbits) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [2:0]         istream_msg_fn,
  input  logic [p_nbits-1:0] istream_msg_a,
  input  logic [p_nbits-1:0] istream_msg_b,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [p_nbits-1:0] ostream_msg,
  output logic               busy
);

  localparam int W = p_nbits;
  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [p_cntbits-1:0] cnt_q, cnt_d;
  logic [2:0]           fn_q, fn_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic [W-1:0]         opb_q, opb_d;     // multiplicand (MUL) or divisor magnitude
  logic [W-1:0]         sh_q, sh_d;       // multiplier (MUL) or dividend/quotient shifter
  logic [W:0]           acc_q, acc_d;     // product (MUL) or partial remainder
  logic [W-1:0]         result_q, result_d;

  logic [W:0]   rem_sh, rem_diff, acc_it;
  logic [W-1:0] sh_it, opb_it, quo_fix, rem_fix;
  logic [W-1:0] a_mag, b_mag;
  logic         sgn_op, last_iter;

`ifdef PROC_MULDIV_EARLY_EXIT_EN
  logic [p_cntbits-1:0] a_sig;
  always_comb begin
    a_sig = p_cntbits'(1);
    for (int i = 0; i < W; i++) begin
      if (istream_msg_a[i]) a_sig = p_cntbits'(i + 1);
    end
  end
`endif

  assign istream_rdy = (state_q == IDLE);
  assign ostream_val = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign ostream_msg = result_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn_d     = fn_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    opb_d    = opb_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    result_d = result_q;

    // One iteration of shift-add or restoring division
    rem_sh   = {acc_q[W-1:0], sh_q[W-1]};
    rem_diff = rem_sh - {1'b0, opb_q};
    if (fn_q == FN_MUL) begin
      acc_it = sh_q[0] ? (acc_q + {1'b0, opb_q}) : acc_q;
      opb_it = opb_q << 1;
      sh_it  = sh_q >> 1;
    end else begin
      acc_it = rem_diff[W] ? rem_sh : rem_diff;
      opb_it = opb_q;
      sh_it  = {sh_q[W-2:0], ~rem_diff[W]};
    end
    quo_fix = negq_q ? (~sh_it + 1'b1) : sh_it;
    rem_fix = negr_q ? (~acc_it[W-1:0] + 1'b1) : acc_it[W-1:0];

    last_iter = (cnt_q == p_cntbits'(1));
`ifdef PROC_MULDIV_EARLY_EXIT_EN
    if (fn_q == FN_MUL && sh_it == '0) last_iter = 1'b1;
`endif

    sgn_op = (istream_msg_fn == FN_DIV) || (istream_msg_fn == FN_REM);
    a_mag  = (sgn_op && istream_msg_a[W-1]) ? (~istream_msg_a + 1'b1) : istream_msg_a;
    b_mag  = (sgn_op && istream_msg_b[W-1]) ? (~istream_msg_b + 1'b1) : istream_msg_b;

    case (state_q)
      IDLE: begin
        if (istream_val) begin
          fn_d   = istream_msg_fn;
          acc_d  = '0;
          negq_d = (istream_msg_fn == FN_DIV) && (istream_msg_a[W-1] ^ istream_msg_b[W-1]);
          negr_d = (istream_msg_fn == FN_REM) && istream_msg_a[W-1];
          cnt_d  = p_cntbits'(W);
          if (istream_msg_fn > FN_REMU) begin
            result_d = '0;
            state_d  = DONE;
          end else if (istream_msg_fn != FN_MUL && istream_msg_b == '0) begin
            result_d = (istream_msg_fn == FN_DIV || istream_msg_fn == FN_DIVU) ? '1 : istream_msg_a;
            state_d  = DONE;
          end else if (sgn_op && istream_msg_a == MIN_VAL && istream_msg_b == '1) begin
            result_d = (istream_msg_fn == FN_DIV) ? istream_msg_a : '0;
            state_d  = DONE;
          end else if (istream_msg_fn == FN_MUL) begin
            opb_d   = istream_msg_a;
            sh_d    = istream_msg_b;
            state_d = CALC;
          end else begin
            opb_d   = b_mag;
            sh_d    = a_mag;
            state_d = CALC;
`ifdef PROC_MULDIV_EARLY_EXIT_EN
            // Skip the dividend's leading zeros by pre-aligning its top set bit
            if (!sgn_op) begin
              cnt_d = a_sig;
              sh_d  = istream_msg_a << (p_cntbits'(W) - a_sig);
            end
`endif
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q - p_cntbits'(1);
        opb_d = opb_it;
        sh_d  = sh_it;
        acc_d = acc_it;
        if (last_iter) begin
          state_d = DONE;
          case (fn_q)
            FN_MUL:          result_d = acc_it[W-1:0];
            FN_DIV, FN_DIVU: result_d = quo_fix;
            default:         result_d = rem_fix;
          endcase
        end
      end
      DONE: begin
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      fn_q     <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      opb_q    <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn_q     <= fn_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      opb_q    <= opb_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_proc_dpath_muldiv_unit.sv
// Directed and random bench for proc_dpath_muldiv_unit with a result scoreboard.
module tb_proc_dpath_muldiv_unit;
  localparam int P = 32;
  localparam logic [P-1:0] MINV = {1'b1, {(P-1){1'b0}}};

  logic         clk = 1'b0;
  logic         reset;
  logic         istream_val;
  logic         istream_rdy;
  logic [2:0]   istream_msg_fn;
  logic [P-1:0] istream_msg_a, istream_msg_b;
  logic         ostream_val, ostream_rdy;
  logic [P-1:0] ostream_msg;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  logic [P-1:0] exp_q[$];

  proc_dpath_muldiv_unit #(.p_nbits(P)) dut (
    .clk(clk), .reset(reset),
    .istream_val(istream_val), .istream_rdy(istream_rdy),
    .istream_msg_fn(istream_msg_fn), .istream_msg_a(istream_msg_a), .istream_msg_b(istream_msg_b),
    .ostream_val(ostream_val), .ostream_rdy(ostream_rdy), .ostream_msg(ostream_msg),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [P-1:0] obs, input logic [P-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [P-1:0] model(input logic [2:0] fn, input logic [P-1:0] a, input logic [P-1:0] b);
    case (fn)
      3'd0: return a * b;
      3'd1: if (b == '0) return '1; else if (a == MINV && b == '1) return a; else return $signed(a) / $signed(b);
      3'd2: if (b == '0) return '1; else return a / b;
      3'd3: if (b == '0) return a; else if (a == MINV && b == '1) return '0; else return $signed(a) % $signed(b);
      3'd4: if (b == '0) return a; else return a % b;
      default: return '0;
    endcase
  endfunction

  function automatic int sigb(input logic [P-1:0] v);
    int n = 0;
    for (int i = 0; i < P; i++) if (v[i]) n = i + 1;
    return (n < 1) ? 1 : n;
  endfunction

  function automatic int exp_lat(input logic [2:0] fn, input logic [P-1:0] a, input logic [P-1:0] b);
    if (fn > 3'd4) return 1;
    if (fn != 3'd0 && b == '0) return 1;
    if ((fn == 3'd1 || fn == 3'd3) && a == MINV && b == '1) return 1;
`ifdef PROC_MULDIV_EARLY_EXIT_EN
    if (fn == 3'd0) return 1 + sigb(b);
    if (fn == 3'd2 || fn == 3'd4) return 1 + sigb(a);
`endif
    return P + 1;
  endfunction

  task automatic send(input logic [2:0] fn, input logic [P-1:0] a, input logic [P-1:0] b, input bit push);
    int g = 0;
    while (!istream_rdy && g < 100) begin @(negedge clk); g++; end
    chk("send_rdy", P'(istream_rdy), P'(1));
    istream_val    = 1'b1;
    istream_msg_fn = fn;
    istream_msg_a  = a;
    istream_msg_b  = b;
    if (push) exp_q.push_back(model(fn, a, b));
    @(posedge clk); #1;
    istream_val    = 1'b0;
    istream_msg_fn = 3'($urandom);
    istream_msg_a  = $urandom;
    istream_msg_b  = $urandom;
  endtask

  task automatic collect(input string tag, input int stall);
    logic [P-1:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    if (stall > 0) begin
      ostream_rdy = 1'b0;
      repeat (stall) @(negedge clk);
    end
    chk({tag, "_msg"}, ostream_msg, e);
    ostream_rdy = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] fn, input logic [P-1:0] a, input logic [P-1:0] b,
                        input string tag, input int stall);
    int lat = 0;
    bit rdy_hi = 1'b0;
    send(fn, a, b, 1'b1);
    do begin
      @(negedge clk);
      lat++;
      if (istream_rdy) rdy_hi = 1'b1;
    end while (!ostream_val && lat < 200);
    chk({tag, "_lat"}, P'(lat), P'(exp_lat(fn, a, b)));
    chk({tag, "_rdy_low"}, P'(rdy_hi), '0);
    if (ostream_val) collect(tag, stall);
    else void'(exp_q.pop_front());
  endtask

  initial begin
    logic [P-1:0] held, ea, eb;
    logic [2:0] rf;
    bit seen;
    int g;
    reset = 1'b1; istream_val = 1'b0; istream_msg_fn = '0;
    istream_msg_a = '0; istream_msg_b = '0; ostream_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_irdy", P'(istream_rdy), P'(1));
    chk("rst_oval", P'(ostream_val), '0);
    chk("rst_omsg", ostream_msg, '0);
    chk("rst_busy", P'(busy), '0);
    reset = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, -32'sd3, "mul_7x-3", 0);
    run_op(3'd1, -32'sd7, 32'd2, "div_-7/2", 0);
    run_op(3'd3, -32'sd7, 32'd2, "rem_-7%2", 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd16, "divu", 0);
    run_op(3'd4, 32'hFFFF_FFFF, 32'd16, "remu", 0);
    run_op(3'd2, 32'd5, 32'd0, "divu_by0", 0);
    run_op(3'd4, 32'd5, 32'd0, "remu_by0", 0);
    run_op(3'd1, 32'd5, 32'd0, "div_by0", 0);
    run_op(3'd3, -32'sd5, 32'd0, "rem_by0", 0);
    run_op(3'd1, MINV, 32'hFFFF_FFFF, "div_ovf", 0);
    run_op(3'd3, MINV, 32'hFFFF_FFFF, "rem_ovf", 0);
    run_op(3'd6, 32'd9, 32'd3, "illegal", 0);
    run_op(3'd1, MINV, 32'd3, "div_min", 0);
    run_op(3'd3, 32'd7, -32'sd2, "rem_pos_neg", 0);

    // Backpressure: result held for 10 cycles
    ostream_rdy = 1'b0;
    send(3'd1, 32'd100, -32'sd7, 1'b1);
    g = 0;
    while (!ostream_val && g < 200) begin @(negedge clk); g++; end
    chk("bp_val_rise", P'(ostream_val), P'(1));
    held = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_val", P'(ostream_val), P'(1));
      chk("bp_msg", ostream_msg, held);
      chk("bp_irdy", P'(istream_rdy), '0);
    end
    collect("bp", 0);
    chk("bp_irdy_after", P'(istream_rdy), P'(1));
    chk("bp_val_after", P'(ostream_val), '0);

    // Reset mid-calculation abandons the op
    send(3'd0, 32'd123, 32'd456, 1'b0);
    repeat (10) @(negedge clk);
    chk("mid_busy", P'(busy), P'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_irdy", P'(istream_rdy), P'(1));
    chk("abort_busy", P'(busy), '0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); if (ostream_val) seen = 1'b1; end
    chk("abort_no_val", P'(seen), '0);
    run_op(3'd0, 32'd2, 32'd3, "mul_2x3", 0);

`ifdef PROC_MULDIV_EARLY_EXIT_EN
    run_op(3'd0, 32'd9, 32'd1, "ee_mul_9x1", 0);
    run_op(3'd0, 32'd9, 32'd0, "ee_mul_x0", 0);
    run_op(3'd2, 32'd100, 32'd7, "ee_divu", 0);
    run_op(3'd4, 32'd0, 32'd7, "ee_remu0", 0);
`endif

    for (int k = 0; k < 1000; k++) begin
      rf = 3'($urandom_range(0, 7));
      if (rf > 3'd4 && $urandom_range(0, 3) != 0) rf = 3'($urandom_range(0, 4));
      ea = $urandom;
      eb = $urandom;
      case ($urandom_range(0, 9))
        0: eb = '0;
        1: begin ea = MINV; eb = '1; end
        2: eb = P'($urandom_range(1, 20));
        3: ea = P'($urandom_range(0, 300));
        4: eb = -P'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(rf, ea, eb, "rand", (k % 7 == 0) ? 2 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/proc_dpath_muldiv_unit.md
Name: proc_dpath_muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit for the X stage of the pipelined processor datapath.
- Successor to the fixed 32-bit multiply-only unit. Adds operand width parameter, signed/unsigned divide and remainder, and RISC-V corner-case semantics.
- Uses a val/rdy request stream from D and a val/rdy response stream into X, so the control unit can stall around it.

Parameters:
- p_nbits, 32, operand and result width (>= 4).
- p_cntbits, $clog2(p_nbits)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- istream_val  input  1  request valid
- istream_rdy  output  1  unit ready for a request
- istream_msg_fn  input  3  operation: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 illegal
- istream_msg_a  input  p_nbits  operand A (rs1 / dividend / multiplicand)
- istream_msg_b  input  p_nbits  operand B (rs2 / divisor / multiplier)
- ostream_val  output  1  result valid
- ostream_rdy  input  1  consumer ready
- ostream_msg  output  p_nbits  result
- busy  output  1  high in CALC or DONE (for stall logic and stats)

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values: state = IDLE, istream_rdy = 1, ostream_val = 0, ostream_msg = 0, busy = 0. Counter and datapath registers reset to 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - istream_rdy = 1.
  - A request is accepted on the edge where istream_val && istream_rdy.
  - Operands and fn are latched on acceptance.
  - Default next state is CALC. Counter loads p_nbits.
- Special cases at acceptance go directly to DONE, with result valid the next cycle:
  - Divide by zero (fn 1-4, b == 0): DIV/DIVU result = all ones; REM/REMU result = a.
  - Signed overflow (fn 1 or 3, a == 1 followed by zeros, b == all ones): DIV result = a; REM result = 0.
  - Illegal fn (5-7): result = 0.
- CALC:
  - istream_rdy = 0.
  - Each cycle performs one iteration and decrements the counter.
  - MUL: shift-add on the multiplier LSB. The product is the low p_nbits of a*b; signedness is irrelevant for the low half.
  - Div/rem: restoring division on |a| and |b| for signed ops, raw operands for unsigned ops.
  - When the counter reaches 1, the next state is DONE with sign fixup applied:
    - Quotient is negated iff operand signs differ (signed DIV).
    - Remainder takes the dividend's sign (signed REM).
- DONE:
  - ostream_val = 1 and ostream_msg is held stable.
  - On ostream_val && ostream_rdy the next state is IDLE.
  - No new request is accepted in DONE, so back-to-back accept is impossible. istream_rdy rises the cycle after the output handshake.
- Latency: request accepted at edge t. Normal ops give ostream_val = 1 from cycle t+p_nbits+1. Special cases give ostream_val = 1 from cycle t+1.
- Backpressure: the unit stays in DONE indefinitely while ostream_rdy = 0. Result and val are held, and no state or data changes.
- istream_val with stale data while not ready is ignored. Inputs are don't-care outside an accept edge.
- Reset asserted in CALC or DONE abandons the operation. The unit returns to IDLE next cycle with no ostream_val pulse.
- Arithmetic width: the internal remainder/accumulator is p_nbits+1 bits. All results are truncated to p_nbits.

Optional Feature:
- Macro: PROC_MULDIV_EARLY_EXIT_EN.
- Defined:
  - For MUL, CALC exits to DONE in the same cycle the remaining multiplier bits become zero. Minimum is 1 CALC cycle; multiplier 0 gives latency 2.
  - For DIVU/REMU, the counter pre-skips leading zero bits of the dividend, loading the counter with the significant bit count (minimum 1).
  - Results are bit-identical to the non-early-exit build.
- Undefined: every normal op takes exactly p_nbits CALC cycles.

Test Plan:
- p_nbits=32, MUL a=7 b=-3 -> ostream_msg=0xFFFFFFEB. Without the macro, ostream_val rises exactly 33 cycles after accept; istream_rdy=0 throughout.
- DIV a=-7 b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU a=0xFFFFFFFF b=16 -> 0x0FFFFFFF; REMU -> 0xF.
- DIVU a=5 b=0 -> 0xFFFFFFFF; REMU -> 5; DIV a=0x80000000 b=-1 -> 0x80000000; REM -> 0. Each has ostream_val one cycle after accept.
- Backpressure: hold ostream_rdy=0 for 10 cycles in DONE -> val/msg stable and istream_rdy=0. Release -> handshake, then istream_rdy=1 the next cycle.
- Assert reset mid-CALC of MUL 123*456 -> no ostream_val. A subsequent MUL 2*3 -> 6 with normal latency.
- p_nbits=8 with macro: MUL a=9 b=1 -> 9 with ostream_val 2 cycles after accept. Randomized 1000 ops vs a golden model in both builds.
